data_mem_responder: RTL

Data-memory responder on the far side of the controller's DRAM_read/DRAM_write strobes. It services single-cycle CPU load/store requests addressed by MAR with write data from MDR, and returns read data for MDR capture. A secondary host port shares the same array through a small arbitration FSM, so the bench or a loader can preload image data and dump results. The CPU always has priority.

---
 rtl/proc_pkg.sv | 14 +
 rtl/data_mem_responder_dram_array.sv | 34 +++
 rtl/data_mem_responder.sv | 120 ++++++++++++
 3 files changed

// File: rtl/proc_pkg.sv
// Shared defaults and host-port FSM state type for the data-memory responder,
// its loader and its testbench.
package proc_pkg;

  localparam int unsigned ADDR_W_DEF = 12;
  localparam int unsigned DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    H_IDLE = 2'd0,
    H_WAIT = 2'd1,
    H_ACK  = 2'd2
  } host_state_e;

endpackage

// File: rtl/data_mem_responder_dram_array.sv
// Single-port synchronous RAM, one access per edge, write-first read port.
// Contents are never cleared by reset.
module dram_array #(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned DATA_W    = 16,
  parameter bit          INIT_ZERO = 1'b0
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  // Time-0 zero fill is a simulation-only property of the storage, not logic.
  localparam bit unused_init_zero = INIT_ZERO;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= wdata;
      r_rdata     <= wdata;
    end else begin
      r_rdata     <= r_mem[addr];
    end
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: CPU load/store port with absolute priority plus a
// host request/ack port arbitrated onto the same single-port array.
module data_mem_responder
  import proc_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter bit          INIT_ZERO = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              DRAM_read,
  input  logic              DRAM_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_ack,
  output logic              err
);

  host_state_e       r_state, w_state_nxt;
  logic              w_busy, w_host_go, w_host_rd_vis;
  logic              w_arr_we;
  logic [ADDR_W-1:0] w_arr_addr;
  logic [DATA_W-1:0] w_arr_wdata, w_arr_rdata;
  logic              r_cpu_rvalid, r_host_rd, r_err;
  logic [DATA_W-1:0] r_cpu_hold, r_host_hold;

  assign w_busy = DRAM_read | DRAM_write;

  always_comb begin
    w_state_nxt = r_state;
    w_host_go   = 1'b0;
    unique case (r_state)
      H_IDLE, H_WAIT: begin
        if (!host_req) begin
          w_state_nxt = H_IDLE;
        end else if (w_busy) begin
          w_state_nxt = H_WAIT;
        end else begin
          w_host_go   = 1'b1;
          w_state_nxt = H_ACK;
        end
      end
      H_ACK:   w_state_nxt = H_IDLE;
      default: w_state_nxt = H_IDLE;
    endcase
    if (reset) begin
      w_host_go = 1'b0;
    end
  end

  always_comb begin
    w_arr_we    = 1'b0;
    w_arr_addr  = host_addr;
    w_arr_wdata = host_wdata;
    if (w_busy) begin
      w_arr_we    = DRAM_write;
      w_arr_addr  = cpu_addr;
      w_arr_wdata = cpu_wdata;
    end else if (w_host_go) begin
      w_arr_we    = host_we;
    end
  end

  dram_array #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .INIT_ZERO (INIT_ZERO)
  ) u_array (
    .clk   (clk),
    .we    (w_arr_we),
    .addr  (w_arr_addr),
    .wdata (w_arr_wdata),
    .rdata (w_arr_rdata)
  );

  assign w_host_rd_vis = (r_state == H_ACK) && r_host_rd;

  // The array output changes every edge, so each port shows it live in its
  // valid cycle and holds a private copy afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= H_IDLE;
      r_cpu_rvalid <= 1'b0;
      r_host_rd    <= 1'b0;
      r_err        <= 1'b0;
      r_cpu_hold   <= '0;
      r_host_hold  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cpu_rvalid <= DRAM_read;
      if (DRAM_read && DRAM_write) begin
        r_err <= 1'b1;
      end
      if (w_host_go) begin
        r_host_rd <= !host_we;
      end
      if (r_cpu_rvalid) begin
        r_cpu_hold <= w_arr_rdata;
      end
      if (w_host_rd_vis) begin
        r_host_hold <= w_arr_rdata;
      end
    end
  end

  assign cpu_rvalid = r_cpu_rvalid;
  assign cpu_rdata  = r_cpu_rvalid ? w_arr_rdata : r_cpu_hold;
  assign host_ack   = (r_state == H_ACK);
  assign host_rdata = w_host_rd_vis ? w_arr_rdata : r_host_hold;
  assign err        = r_err;

endmodule
